// File: rtl/frame_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_timing_pkg
//  Description : Shared definitions for the frame timing configuration
//                sequencer: supported resolution codes, the timing parameter
//                set handed to the generator, and the sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_timing_pkg;

    // Supported resolution codes
    localparam logic [4:0] RES_720P60  = 5'h08;
    localparam logic [4:0] RES_1080P60 = 5'h10;
    localparam logic [4:0] RES_1080I50 = 5'h12;
    localparam logic [4:0] RES_1080I60 = 5'h13;

    // Full timing set; field order is also the MSB-to-LSB packing order
    typedef struct packed {
        logic [12:0] hs_total;
        logic [12:0] vs_total;
        logic [12:0] hsyn_num;
        logic [12:0] vsyn_num;
        logic [12:0] start_pix;
        logic [12:0] end_pix;
        logic [12:0] start_h;
        logic [12:0] end_h;
    } timing_set_t;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_DISABLE    = 3'd2,
        ST_QUIET      = 3'd3,
        ST_LOAD       = 3'd4,
        ST_ENABLE     = 3'd5,
        ST_LOCK       = 3'd6
    } ftc_state_e;

endpackage
`default_nettype wire

// File: rtl/frame_timing_rom.sv
`default_nettype none
// ============================================================================
//  Module      : frame_timing_rom
//  Description : Combinational lookup from resolution code to timing set.
//  Ports       : i_code  - resolution code to look up
//                o_set   - timing set for the code (all zero if unsupported)
//                o_valid - high when the code is supported
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_timing_rom
    import frame_timing_pkg::*;
(
    input  logic [4:0]  i_code,
    output timing_set_t o_set,
    output logic        o_valid
);

    always_comb begin
        o_set   = '0;
        o_valid = 1'b0;
        case (i_code)
            RES_720P60: begin
                o_set   = {13'd1649, 13'd750, 13'd39, 13'd5,
                           13'd259, 13'd1539, 13'd25, 13'd745};
                o_valid = 1'b1;
            end
            RES_1080P60, RES_1080I60: begin
                o_set   = {13'd2199, 13'd1125, 13'd43, 13'd5,
                           13'd191, 13'd2111, 13'd41, 13'd1121};
                o_valid = 1'b1;
            end
            RES_1080I50: begin
                o_set   = {13'd2639, 13'd1125, 13'd43, 13'd5,
                           13'd191, 13'd2111, 13'd41, 13'd1121};
                o_valid = 1'b1;
            end
            default: begin
                o_set   = '0;
                o_valid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/frame_timing_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_timing_cfg_ctrl
//  Description : Resolution-change sequencer for the frame timing generator.
//                Waits for a frame boundary, disables the generator, holds it
//                quiet, loads the new timing set, re-enables and confirms lock
//                on the first new vsync.
//  Ports       : i_clk/i_rst        - pixel clock, async active-high reset
//                i_req_valid/code   - change request; o_req_ready in IDLE only
//                i_vsyn             - generator vsync (same clock domain)
//                o_frm_gen_enable   - generator enable
//                o_resolution, o_hs_total .. o_end_h - active timing set
//                o_busy/o_locked    - status; o_done/o_err - one-cycle pulses
//  Config      : FTC_TIMEOUT_EN - enables the WAIT_FRAME/LOCK watchdog
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_timing_cfg_ctrl
    import frame_timing_pkg::*;
#(
    parameter int P_QUIET_CYC = 16,
    parameter int P_TIMEOUT   = 2_000_000,
    parameter int P_CNT_W     = 21
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic [4:0]  i_req_code,
    output logic        o_req_ready,
    input  logic        i_vsyn,
    output logic        o_frm_gen_enable,
    output logic [4:0]  o_resolution,
    output logic [12:0] o_hs_total,
    output logic [12:0] o_vs_total,
    output logic [12:0] o_hsyn_num,
    output logic [12:0] o_vsyn_num,
    output logic [12:0] o_start_pix,
    output logic [12:0] o_end_pix,
    output logic [12:0] o_start_h,
    output logic [12:0] o_end_h,
    output logic        o_busy,
    output logic        o_locked,
    output logic        o_done,
    output logic        o_err
);

    // Without the watchdog the counter only has to span the quiet period
`ifdef FTC_TIMEOUT_EN
    localparam int c_cnt_w = P_CNT_W;
`else
    localparam int c_cnt_w = $clog2(P_QUIET_CYC + 1);
`endif

    generate
        if ((P_QUIET_CYC < 4) || ((P_CNT_W < 31) && (P_TIMEOUT >= (1 << P_CNT_W)))) begin : g_bad_params
            $error("frame_timing_cfg_ctrl: P_QUIET_CYC must be >= 4 and P_CNT_W must hold P_TIMEOUT");
        end
    endgenerate

    ftc_state_e         r_state;
    ftc_state_e         w_state_nxt;
    logic [4:0]         r_code;
    logic               r_vsyn_d;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_en;
    logic [4:0]         r_res;
    timing_set_t        r_set;
    logic               r_busy;
    logic               r_locked;
    logic               r_done;
    logic               r_err;

    logic [4:0]         w_rom_code;
    timing_set_t        w_rom_set;
    logic               w_rom_valid;
    logic               w_rise;
    logic               w_same;
    logic               w_quiet_last;
    logic               w_tmo;
    logic               w_wdog_run;
    logic               w_cnt_run;

    // One lookup serves both the acceptance check (live code in IDLE) and
    // the load (latched code afterwards).
    assign w_rom_code = (r_state == ST_IDLE) ? i_req_code : r_code;

    frame_timing_rom u_rom (
        .i_code  (w_rom_code),
        .o_set   (w_rom_set),
        .o_valid (w_rom_valid)
    );

    // r_vsyn_d always tracks, but a rise only matters in WAIT_FRAME/LOCK, so a
    // rise seen on the accept cycle itself is never counted.
    assign w_rise       = i_vsyn & ~r_vsyn_d;
    assign w_same       = (i_req_code == r_res) && r_locked;
    assign w_quiet_last = (r_cnt == c_cnt_w'(P_QUIET_CYC - 1));

`ifdef FTC_TIMEOUT_EN
    assign w_tmo      = (r_cnt == c_cnt_w'(P_TIMEOUT - 1));
    assign w_wdog_run = (r_state == ST_WAIT_FRAME) || (r_state == ST_LOCK);
`else
    assign w_tmo      = 1'b0;
    assign w_wdog_run = 1'b0;
`endif

    // Counter restarts from zero on every state entry
    assign w_cnt_run = ((r_state == ST_QUIET) && !w_quiet_last) ||
                       (w_wdog_run && !w_rise && !w_tmo);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid && w_rom_valid && !w_same) begin
                    w_state_nxt = r_en ? ST_WAIT_FRAME : ST_LOAD;
                end
            end
            ST_WAIT_FRAME: if (w_rise || w_tmo) w_state_nxt = ST_DISABLE;
            ST_DISABLE:    w_state_nxt = ST_QUIET;
            ST_QUIET:      if (w_quiet_last) w_state_nxt = ST_LOAD;
            ST_LOAD:       w_state_nxt = ST_ENABLE;
            ST_ENABLE:     w_state_nxt = ST_LOCK;
            ST_LOCK:       if (w_rise || w_tmo) w_state_nxt = ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_code   <= '0;
            r_vsyn_d <= 1'b0;
            r_cnt    <= '0;
            r_en     <= 1'b0;
            r_res    <= '0;
            r_set    <= '0;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_vsyn_d <= i_vsyn;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= w_cnt_run ? r_cnt + 1'b1 : '0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_code <= i_req_code;
                        if (!w_rom_valid) begin
                            r_err <= 1'b1;
                        end else if (w_same) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_DISABLE: begin
                    r_en     <= 1'b0;
                    r_locked <= 1'b0;
                end
                ST_LOAD: begin
                    r_set <= w_rom_set;
                    r_res <= r_code;
                end
                ST_ENABLE: r_en <= 1'b1;
                ST_LOCK: begin
                    if (w_rise) begin
                        r_locked <= 1'b1;
                        r_done   <= 1'b1;
                    end else if (w_tmo) begin
                        // Lock timeout leaves the generator running, unlocked
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready      = (r_state == ST_IDLE);
    assign o_frm_gen_enable = r_en;
    assign o_resolution     = r_res;
    assign o_hs_total       = r_set.hs_total;
    assign o_vs_total       = r_set.vs_total;
    assign o_hsyn_num       = r_set.hsyn_num;
    assign o_vsyn_num       = r_set.vsyn_num;
    assign o_start_pix      = r_set.start_pix;
    assign o_end_pix        = r_set.end_pix;
    assign o_start_h        = r_set.start_h;
    assign o_end_h          = r_set.end_h;
    assign o_busy           = r_busy;
    assign o_locked         = r_locked;
    assign o_done           = r_done;
    assign o_err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_timing_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_timing_cfg_ctrl
//  Description : Self-checking bench for frame_timing_cfg_ctrl. Requests are
//                issued and their outcome is predicted at transaction level
//                from the timing table and the sequencing latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_timing_cfg_ctrl;
    import frame_timing_pkg::*;

    typedef logic [127:0] v_t;
    localparam int QUIET = 16;
    localparam int TMO   = 100;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic [4:0]  i_req_code = 5'd0;
    logic        i_vsyn = 1'b0;
    logic        o_req_ready, o_frm_gen_enable, o_busy, o_locked, o_done, o_err;
    logic [4:0]  o_resolution;
    logic [12:0] o_hs_total, o_vs_total, o_hsyn_num, o_vsyn_num;
    logic [12:0] o_start_pix, o_end_pix, o_start_h, o_end_h;
    logic [103:0] obs_set;

    int n_vec = 0;
    int n_mis = 0;

    // Reference state: what the generator should currently be running with
    logic         m_en = 1'b0;
    logic         m_locked = 1'b0;
    logic [4:0]   m_res = 5'd0;
    logic [103:0] m_set = '0;

    frame_timing_cfg_ctrl #(
        .P_QUIET_CYC (QUIET),
        .P_TIMEOUT   (TMO),
        .P_CNT_W     (21)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req_valid      (i_req_valid),
        .i_req_code       (i_req_code),
        .o_req_ready      (o_req_ready),
        .i_vsyn           (i_vsyn),
        .o_frm_gen_enable (o_frm_gen_enable),
        .o_resolution     (o_resolution),
        .o_hs_total       (o_hs_total),
        .o_vs_total       (o_vs_total),
        .o_hsyn_num       (o_hsyn_num),
        .o_vsyn_num       (o_vsyn_num),
        .o_start_pix      (o_start_pix),
        .o_end_pix        (o_end_pix),
        .o_start_h        (o_start_h),
        .o_end_h          (o_end_h),
        .o_busy           (o_busy),
        .o_locked         (o_locked),
        .o_done           (o_done),
        .o_err            (o_err)
    );

    assign obs_set = {o_hs_total, o_vs_total, o_hsyn_num, o_vsyn_num,
                      o_start_pix, o_end_pix, o_start_h, o_end_h};

    always #5 i_clk = ~i_clk;

    initial begin
        #800_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input v_t act, input v_t exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    function automatic bit tab_ok(input logic [4:0] c);
        return (c == 5'h08) || (c == 5'h10) || (c == 5'h12) || (c == 5'h13);
    endfunction

    function automatic logic [103:0] tab_set(input logic [4:0] c);
        logic [103:0] s;
        case (c)
            5'h08:        s = {13'd1649, 13'd750,  13'd39, 13'd5, 13'd259, 13'd1539, 13'd25, 13'd745};
            5'h10, 5'h13: s = {13'd2199, 13'd1125, 13'd43, 13'd5, 13'd191, 13'd2111, 13'd41, 13'd1121};
            5'h12:        s = {13'd2639, 13'd1125, 13'd43, 13'd5, 13'd191, 13'd2111, 13'd41, 13'd1121};
            default:      s = '0;
        endcase
        return s;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},    v_t'(o_frm_gen_enable), v_t'(0));
        chk({tag, "_res"},   v_t'(o_resolution),     v_t'(0));
        chk({tag, "_set"},   v_t'(obs_set),          v_t'(0));
        chk({tag, "_ready"}, v_t'(o_req_ready),      v_t'(1));
        chk({tag, "_busy"},  v_t'(o_busy),           v_t'(0));
        chk({tag, "_lock"},  v_t'(o_locked),         v_t'(0));
        chk({tag, "_done"},  v_t'(o_done),           v_t'(0));
        chk({tag, "_err"},   v_t'(o_err),            v_t'(0));
    endtask

    // Entered on the first cycle the generator is enabled again
    task automatic lock_phase(input logic [4:0] code);
        int j;
        j = $urandom_range(1, 6);
        for (int i = 0; i < j; i++) begin
            chk("lockwait_locked", v_t'(o_locked), v_t'(0));
            chk("lockwait_busy",   v_t'(o_busy),   v_t'(1));
            step();
        end
        i_vsyn = 1'b1;
        step();
        chk("lock_locked", v_t'(o_locked),         v_t'(1));
        chk("lock_done",   v_t'(o_done),           v_t'(1));
        chk("lock_busy",   v_t'(o_busy),           v_t'(0));
        chk("lock_en",     v_t'(o_frm_gen_enable), v_t'(1));
        chk("lock_res",    v_t'(o_resolution),     v_t'(code));
        chk("lock_set",    v_t'(obs_set),          v_t'(tab_set(code)));
        step();
        chk("done_once",   v_t'(o_done),      v_t'(0));
        chk("ready_back",  v_t'(o_req_ready), v_t'(1));
        i_vsyn   = 1'b0;
        m_en     = 1'b1;
        m_locked = 1'b1;
        m_res    = code;
        m_set    = tab_set(code);
    endtask

    task automatic do_req(input logic [4:0] code, input bit coin);
        logic [103:0] old_set, new_set;
        int k, low, seen_new;
        old_set = m_set;
        new_set = tab_set(code);
        chk("req_ready", v_t'(o_req_ready), v_t'(1));
        i_req_valid = 1'b1;
        i_req_code  = code;
        if (coin) i_vsyn = 1'b1;
        step();
        i_req_valid = 1'b0;
        i_req_code  = 5'($urandom_range(0, 31));
        if (!tab_ok(code)) begin
            chk("bad_err",  v_t'(o_err),            v_t'(1));
            chk("bad_done", v_t'(o_done),           v_t'(0));
            chk("bad_busy", v_t'(o_busy),           v_t'(0));
            chk("bad_en",   v_t'(o_frm_gen_enable), v_t'(m_en));
            chk("bad_lock", v_t'(o_locked),         v_t'(m_locked));
            chk("bad_res",  v_t'(o_resolution),     v_t'(m_res));
            chk("bad_set",  v_t'(obs_set),          v_t'(old_set));
            step();
            chk("bad_err_once", v_t'(o_err), v_t'(0));
            i_vsyn = 1'b0;
        end else if ((code == m_res) && m_locked) begin
            chk("same_done", v_t'(o_done),           v_t'(1));
            chk("same_err",  v_t'(o_err),            v_t'(0));
            chk("same_busy", v_t'(o_busy),           v_t'(0));
            chk("same_en",   v_t'(o_frm_gen_enable), v_t'(1));
            step();
            chk("same_done_once", v_t'(o_done),           v_t'(0));
            chk("same_en_hold",   v_t'(o_frm_gen_enable), v_t'(1));
            i_vsyn = 1'b0;
        end else if (!m_en) begin
            i_vsyn = 1'b0;
            chk("cold_busy", v_t'(o_busy),           v_t'(1));
            chk("cold_en",   v_t'(o_frm_gen_enable), v_t'(0));
            chk("cold_old",  v_t'(obs_set),          v_t'(old_set));
            step();
            chk("cold_set",  v_t'(obs_set),          v_t'(new_set));
            chk("cold_res",  v_t'(o_resolution),     v_t'(code));
            chk("cold_en_l", v_t'(o_frm_gen_enable), v_t'(0));
            step();
            chk("cold_en_h", v_t'(o_frm_gen_enable), v_t'(1));
            chk("cold_lock", v_t'(o_locked),         v_t'(0));
            lock_phase(code);
        end else begin
            chk("wf_busy",  v_t'(o_busy),           v_t'(1));
            chk("wf_ready", v_t'(o_req_ready),      v_t'(0));
            chk("wf_en",    v_t'(o_frm_gen_enable), v_t'(1));
            if (coin) begin
                // vsync already rising on the accept cycle must be ignored
                step();
                chk("coin_en", v_t'(o_frm_gen_enable), v_t'(1));
                i_vsyn = 1'b0;
            end
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                step();
                chk("wf_hold_en",  v_t'(o_frm_gen_enable), v_t'(1));
                chk("wf_hold_set", v_t'(obs_set),          v_t'(old_set));
            end
            i_vsyn = 1'b1;
            step();
            chk("vs1_en", v_t'(o_frm_gen_enable), v_t'(1));
            step();
            chk("vs2_en",   v_t'(o_frm_gen_enable), v_t'(0));
            chk("vs2_lock", v_t'(o_locked),         v_t'(0));
            chk("vs2_set",  v_t'(obs_set),          v_t'(old_set));
            i_vsyn   = 1'b0;
            low      = 1;
            seen_new = 0;
            while (low < 200) begin
                step();
                if (o_frm_gen_enable) break;
                low++;
                if (obs_set == new_set) seen_new++;
            end
            // DISABLE cycle, QUIET period, then LOAD
            chk("quiet_len", v_t'(low),          v_t'(QUIET + 2));
            chk("ren_set",   v_t'(obs_set),      v_t'(new_set));
            chk("ren_res",   v_t'(o_resolution), v_t'(code));
            if (new_set != old_set) chk("param_lead", v_t'(seen_new), v_t'(1));
            lock_phase(code);
        end
        step();
    endtask

    initial begin
        logic [4:0] sup [4];
        logic [4:0] c;
        sup[0] = RES_720P60;
        sup[1] = RES_1080P60;
        sup[2] = RES_1080I50;
        sup[3] = RES_1080I60;

        step();
        chk_reset_vals("rst_hold");
        step();
        i_rst = 1'b0;
        step();
        chk_reset_vals("rst_rel");

        do_req(RES_1080P60, 1'b0);
        do_req(RES_720P60, 1'b0);
        do_req(RES_1080P60, 1'b1);
        do_req(5'h1F, 1'b0);
        do_req(RES_1080P60, 1'b0);
        do_req(RES_1080I60, 1'b0);

        // Reset while the generator is held quiet
        i_req_valid = 1'b1;
        i_req_code  = RES_720P60;
        step();
        i_req_valid = 1'b0;
        step();
        i_vsyn = 1'b1;
        step();
        step();
        i_vsyn = 1'b0;
        step();
        step();
        #2 i_rst = 1'b1;
        #1 chk_reset_vals("rst_mid");
        step();
        i_rst = 1'b0;
        m_en = 1'b0; m_locked = 1'b0; m_res = 5'd0; m_set = '0;
        step();
        chk_reset_vals("rst_after");
        do_req(RES_1080I50, 1'b0);

`ifdef FTC_TIMEOUT_EN
        begin
            int n;
            logic [103:0] ns;
            i_rst = 1'b1;
            step();
            i_rst = 1'b0;
            m_en = 1'b0; m_locked = 1'b0; m_res = 5'd0; m_set = '0;
            step();
            ns = tab_set(RES_1080I60);
            i_req_valid = 1'b1;
            i_req_code  = RES_1080I60;
            step();
            i_req_valid = 1'b0;
            step();
            step();
            chk("tmo_en", v_t'(o_frm_gen_enable), v_t'(1));
            n = 0;
            while (!o_err && n < 300) begin
                step();
                n++;
            end
            chk("tmo_cycles", v_t'(n),                v_t'(TMO));
            chk("tmo_lock",   v_t'(o_locked),         v_t'(0));
            chk("tmo_busy",   v_t'(o_busy),           v_t'(0));
            chk("tmo_en_kept", v_t'(o_frm_gen_enable), v_t'(1));
            m_en = 1'b1; m_locked = 1'b0; m_res = RES_1080I60; m_set = ns;
            step();
            do_req(RES_1080I60, 1'b0);
        end
`endif

        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 1) == 1) c = sup[$urandom_range(0, 3)];
            else c = 5'($urandom_range(0, 31));
            do_req(c, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_timing_cfg_ctrl.md
# frame_timing_cfg_ctrl

Sequencer for `frame_timming_gen`. It accepts resolution-change requests, looks up the timing parameter set for the requested code, and reconfigures the generator safely. Safe means: wait for a frame boundary, drop the generator enable, hold quiet, load the new parameters, re-enable, then confirm lock on the first new vsync. It sits between the register/host control path and the timing generator, and it owns the generator's enable and all timing inputs.

## Interface
- P_QUIET_CYC, 16: cycles the enable stays low before new parameters load (min 4).
- P_TIMEOUT, 2_000_000: watchdog limit in cycles (used only with FTC_TIMEOUT_EN).
- P_CNT_W, 21: width of the quiet/watchdog counter; must hold P_TIMEOUT.
- i_clk  in  1  pixel clock, shared with the generator.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  resolution change request.
- i_req_code  in  5  requested resolution code.
- o_req_ready  out  1  high only in IDLE.
- i_vsyn  in  1  generator o_vsyn, same clock domain.
- o_frm_gen_enable  out  1  drives generator i_frm_gen_enable.
- o_resolution  out  5  active code, to generator i_resolution.
- o_hs_total, o_vs_total, o_hsyn_num, o_vsyn_num, o_start_pix, o_end_pix, o_start_h, o_end_h  out  13 each  timing set to the generator.
- o_busy  out  1  high in any state other than IDLE.
- o_locked  out  1  generator running with the current set and vsync confirmed.
- o_done  out  1  one-cycle pulse when a request completes.
- o_err  out  1  one-cycle pulse on an unsupported code or a lock timeout.

## Operation
- States: IDLE, WAIT_FRAME, DISABLE, QUIET, LOAD, ENABLE, LOCK.
- Acceptance: a request is accepted when i_req_valid & o_req_ready; the code is latched.
- Unsupported code: o_err pulses, o_done does not pulse, and the FSM stays in IDLE with no output change.
- Same code already active: if the code equals o_resolution and o_locked=1, o_done pulses and the FSM stays in IDLE.
- Normal request: IDLE goes to WAIT_FRAME. If o_frm_gen_enable=0, it goes to LOAD instead.
- WAIT_FRAME: waits for the rising edge of i_vsyn (registered compare), then goes to DISABLE.
- DISABLE: drives o_frm_gen_enable=0 and o_locked=0. The next cycle goes to QUIET.
- QUIET: counts P_QUIET_CYC cycles, then goes to LOAD.
- LOAD: all timing outputs and o_resolution take the looked-up values, then the FSM goes to ENABLE.
- ENABLE: o_frm_gen_enable=1, then the FSM goes to LOCK.
- LOCK: on the first i_vsyn rising edge, o_locked=1 and o_done pulses, then the FSM returns to IDLE.
- Output stability: timing outputs change only in LOAD and never while o_frm_gen_enable=1.
- Requests outside IDLE are not accepted; i_req_valid must be held until ready.
- Edge detection: an i_vsyn rise that coincides with the transition into WAIT_FRAME is not counted. The edge detector is armed only from the first WAIT_FRAME cycle.
- Reset mid-operation: all state is discarded and the FSM returns to IDLE. The generator is left disabled; no auto-restart.

## Timing
- Reset values: o_frm_gen_enable=0, o_resolution=0, all 13-bit timing outputs=0, o_req_ready=1, o_busy=0, o_locked=0, o_done=0, o_err=0.
- Accept on cycle T: o_busy=1 at T+1.
- Vsync rise detected on cycle V: o_frm_gen_enable=0 at V+2.
- LOAD cycle L: new parameters are visible at L+1, and enable=1 at L+2.
- Lock latency: o_locked and o_done assert one cycle after the detected i_vsyn rise.
- Outputs are all registered; there is no combinational path from inputs to outputs except o_req_ready, which is a state decode.

## Configuration
- FTC_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT_FRAME and LOCK.
  - WAIT_FRAME exceeding P_TIMEOUT goes to DISABLE anyway, covering a stalled generator.
  - LOCK exceeding P_TIMEOUT pulses o_err, leaves o_locked=0 and enable=1, and returns to IDLE.
- FTC_TIMEOUT_EN undefined: both states wait indefinitely, and the watchdog counter is not synthesised.

## Structure
- Package `frame_timing_pkg` holds:
  - the resolution code constants: RES_720P60=5'h08, RES_1080P60=5'h10, RES_1080I50=5'h12, RES_1080I60=5'h13;
  - the packed struct `timing_set_t` with the eight 13-bit fields;
  - the FSM state enum.
- Sub-module `frame_timing_rom` is a combinational code→timing_set_t lookup with a `valid` output for supported codes.
- Table values:
  - 720P60: 1649/750/39/5/259/1539/25/745.
  - 1080P60: 2199/1125/43/5/191/2111/41/1121.
  - 1080I60: as 1080P60.
  - 1080I50: hs_total 2639, otherwise as 1080P60.

## Test plan
- From reset, request 5'h10: FSM skips WAIT_FRAME; outputs become hs_total=2199, vs_total=1125; enable rises 2 cycles after LOAD; o_locked and o_done follow the first generator vsync.
- Locked at 5'h10, request 5'h08: enable drops 2 cycles after a vsync rise and stays low ≥16 cycles; hs_total=1649; o_locked returns after re-lock.
- Request 5'h1F: o_err pulses 1 cycle; no output changes; o_busy stays 0.
- Locked at 5'h10, request 5'h10: o_done pulses, enable never drops.
- Assert i_rst during QUIET: all outputs return to their reset values immediately; a new request then completes normally.
- With FTC_TIMEOUT_EN and P_TIMEOUT=100, i_vsyn held 0 in LOCK: o_err pulses at cycle 100, o_locked=0, FSM in IDLE.
